// File: rtl/pll_lock_sequencer.sv
// PLL lock sequencer: pulses PLL RESET, waits for a qualified LOCK with
// timeout and bounded retries, then releases the core reset. Loss of lock
// in RUN re-sequences the PLL. All outputs are registered.
module pll_lock_sequencer #(
  parameter int unsigned RST_CYC    = 16,
  parameter int unsigned LOCK_TMO   = 65536,
  parameter int unsigned STABLE_CYC = 4096,
  parameter int unsigned MAX_RETRY  = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pll_lock,
  output logic       pll_reset,
  output logic       core_reset,
  output logic       ready,
  output logic       fail,
  output logic [3:0] retry_cnt,
  output logic       lock_lost
);

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  localparam int unsigned CW = $clog2(max3(RST_CYC, LOCK_TMO, STABLE_CYC));

  localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYC - 1);
  localparam logic [CW-1:0] TMO_LAST    = CW'(LOCK_TMO - 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYC - 1);
  localparam logic [3:0]    RETRY_MAX   = 4'(MAX_RETRY);

  localparam logic [2:0] S_PLL_RST   = 3'd0;
  localparam logic [2:0] S_WAIT_LOCK = 3'd1;
  localparam logic [2:0] S_STABLE    = 3'd2;
  localparam logic [2:0] S_RUN       = 3'd3;
  localparam logic [2:0] S_FAIL      = 3'd4;

  logic [2:0]    state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [3:0]    retry_d;
  logic          lost_d;
  logic          lock_m, lock_s;

  // Two-flop synchronizer for the asynchronous PLL lock indication
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_m <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      lock_m <= pll_lock;
      lock_s <= lock_m;
    end
  end

  // Next-state, counter and retry bookkeeping
  always_comb begin
    state_d = state;
    cnt_d   = cnt + 1'b1;
    retry_d = retry_cnt;
    lost_d  = 1'b0;
    case (state)
      S_PLL_RST: begin
        if (cnt == RST_LAST) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end
      end
      S_WAIT_LOCK: begin
        // lock takes priority over a coincident timeout
        if (lock_s) begin
          state_d = S_STABLE;
          cnt_d   = '0;
        end else if (cnt == TMO_LAST) begin
          cnt_d = '0;
          if (retry_cnt < RETRY_MAX) begin
            retry_d = retry_cnt + 4'd1;
            state_d = S_PLL_RST;
          end else begin
            state_d = S_FAIL;
          end
        end
      end
      S_STABLE: begin
        if (!lock_s) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt == STABLE_LAST) begin
          state_d = S_RUN;
          cnt_d   = '0;
          retry_d = '0;
        end
      end
      S_RUN: begin
        cnt_d = '0;
        if (!lock_s) begin
          state_d = S_PLL_RST;
          lost_d  = 1'b1;
        end
      end
      S_FAIL: begin
        cnt_d = '0;
      end
      default: begin
        state_d = S_PLL_RST;
        cnt_d   = '0;
      end
    endcase
  end

  // State registers; outputs decoded from the next state so they change on
  // the same edge as the state they describe
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_PLL_RST;
      cnt        <= '0;
      retry_cnt  <= '0;
      pll_reset  <= 1'b1;
      core_reset <= 1'b1;
      ready      <= 1'b0;
      fail       <= 1'b0;
      lock_lost  <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      retry_cnt  <= retry_d;
      pll_reset  <= (state_d == S_PLL_RST) || (state_d == S_FAIL);
      core_reset <= (state_d != S_RUN);
      ready      <= (state_d == S_RUN);
      fail       <= (state_d == S_FAIL);
      lock_lost  <= lost_d;
    end
  end

endmodule
